tdm_demux_4ch: RTL and testbench



---
 rtl/tdm_demux_4ch.sv | 146 ++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of a 4-slot TDM link. It aligns to the frame-start marker and
// collects slots 0..3. A complete frame is published on O0..O3 in a single update, and the
// block keeps frame and sync-error counters for the link status logic.
module tdm_demux_4ch #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ERR_W = 8,
    parameter int unsigned FRM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             fs,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic             frame_valid,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             sync_err,
    output logic [FRM_W-1:0] frame_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [0:0] {StHunt, StLock} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] shadow2_q, shadow2_d;
    logic [WIDTH-1:0] o0_q, o0_d, o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Next-state: slot tracking, shadow capture, frame publish and counters.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        o0_d          = o0_q;
        o1_d          = o1_q;
        o2_d          = o2_q;
        o3_d          = o3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;

        if (din_valid) begin
            unique case (state_q)
                StHunt: begin
                    // Words before the first marker are dropped silently.
                    if (fs) begin
                        shadow0_d = din;
                        sel_d     = 2'd1;
                        state_d   = StLock;
                    end
                end
                StLock: begin
                    if (fs) begin
                        // An early marker abandons the partial frame and restarts at slot 0.
                        sync_err_d = (sel_q != 2'd0);
                        shadow0_d  = din;
                        sel_d      = 2'd1;
                    end else if (sel_q == 2'd0) begin
                        // Missing marker: alignment lost.
                        sync_err_d = 1'b1;
                        state_d    = StHunt;
                    end else if (sel_q == 2'd3) begin
                        o0_d          = shadow0_q;
                        o1_d          = shadow1_q;
                        o2_d          = shadow2_q;
                        o3_d          = din;
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 1'b1;
                        sel_d         = 2'd0;
                    end else begin
                        if (sel_q == 2'd1) begin
                            shadow1_d = din;
                        end else begin
                            shadow2_d = din;
                        end
                        sel_d = sel_q + 2'd1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        // Error counter sticks at all-ones.
        if (sync_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt;
            sel_q         <= 2'd0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            o0_q          <= '0;
            o1_q          <= '0;
            o2_q          <= '0;
            o3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            o0_q          <= o0_d;
            o1_q          <= o1_d;
            o2_q          <= o2_d;
            o3_q          <= o3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign O0          = o0_q;
    assign O1          = o1_q;
    assign O2          = o2_q;
    assign O3          = o3_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign sel         = sel_q;
    assign locked      = (state_q == StLock);
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: queue-based frame model plus scoreboard monitor on the falling edge.
module tb_tdm_demux_4ch;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned FRM_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             fs = 1'b0;
    logic [WIDTH-1:0] O0, O1, O2, O3;
    logic             frame_valid, locked, sync_err;
    logic [1:0]       sel;
    logic [FRM_W-1:0] frame_cnt;
    logic [ERR_W-1:0] err_cnt;

    tdm_demux_4ch #(.WIDTH(WIDTH), .ERR_W(ERR_W), .FRM_W(FRM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .fs          (fs),
        .O0          (O0),
        .O1          (O1),
        .O2          (O2),
        .O3          (O3),
        .frame_valid (frame_valid),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: alignment flag plus the words collected so far in this frame.
    bit               m_aligned;
    logic [WIDTH-1:0] m_part[$];
    logic [FRM_W-1:0] m_fcnt;
    logic [ERR_W-1:0] m_ecnt;
    logic [31:0]      m_last;
    bit               m_fv, m_se;
    logic [31:0]      exp_frames[$];
    logic [ERR_W-1:0] exp_errs[$];
    bit               mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_err();
        m_se = 1'b1;
        if (m_ecnt != {ERR_W{1'b1}}) m_ecnt++;
        exp_errs.push_back(m_ecnt);
    endtask

    task automatic model_step(input bit v, input bit f, input logic [WIDTH-1:0] d);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (!v) return;
        if (!m_aligned) begin
            if (f) begin
                m_aligned = 1'b1;
                m_part.delete();
                m_part.push_back(d);
            end
        end else if (f) begin
            if (m_part.size() != 0) model_err();
            m_part.delete();
            m_part.push_back(d);
        end else if (m_part.size() == 0) begin
            model_err();
            m_aligned = 1'b0;
        end else begin
            m_part.push_back(d);
            if (m_part.size() == 4) begin
                m_last = {m_part[0], m_part[1], m_part[2], m_part[3]};
                exp_frames.push_back(m_last);
                m_fcnt++;
                m_fv = 1'b1;
                m_part.delete();
            end
        end
    endtask

    task automatic model_reset();
        m_aligned = 1'b0;
        m_part.delete();
        m_fcnt = '0;
        m_ecnt = '0;
        m_last = '0;
        m_fv   = 1'b0;
        m_se   = 1'b0;
        exp_frames.delete();
        exp_errs.delete();
    endtask

    // One clock: apply inputs, let the edge sample them, advance the model.
    task automatic cyc(input bit v, input bit f, input logic [WIDTH-1:0] d);
        din_valid = v;
        fs        = f;
        din       = d;
        @(posedge clk);
        model_step(v, f, d);
        #1;
        din_valid = 1'b0;
        fs        = 1'b0;
    endtask

    task automatic frame4(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, i == 0, w[31-8*i -: 8]);
            repeat (gap) cyc(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares every cycle and pops expected data on each pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("frame_valid", 64'(frame_valid), 64'(m_fv));
            chk("sync_err", 64'(sync_err), 64'(m_se));
            chk("locked", 64'(locked), 64'(m_aligned));
            chk("sel", 64'(sel), m_aligned ? 64'(m_part.size()) : 64'd0);
            chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
            chk("err_cnt", 64'(err_cnt), 64'(m_ecnt));
            if (frame_valid) begin
                if (exp_frames.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_data: unexpected frame %0h at %0t", {O0, O1, O2, O3}, $time);
                end else begin
                    chk("frame_data", 64'({O0, O1, O2, O3}), 64'(exp_frames.pop_front()));
                end
            end else begin
                chk("outputs_hold", 64'({O0, O1, O2, O3}), 64'(m_last));
            end
            if (sync_err) begin
                if (exp_errs.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL err_event: unexpected sync_err at %0t", $time);
                end else begin
                    chk("err_event_cnt", 64'(err_cnt), 64'(exp_errs.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 64'({O0, O1, O2, O3}), 64'd0);
        chk("rst_counts", 64'({frame_cnt, err_cnt}), 64'd0);
        chk("rst_flags", 64'({frame_valid, sync_err, locked, sel}), 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Contiguous aligned frame.
        frame4(32'h11223344, 0);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk("first_frame", 64'({O0, O1, O2, O3, frame_cnt}), 64'h11223344_0001);

        // Hunt discards unmarked words.
        do_reset();
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h66);
        cyc(1'b1, 1'b0, 8'h77);
        frame4(32'hA0A1A2A3, 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("hunt_frame", 64'({O0, O1, O2, O3, err_cnt}), 64'hA0A1A2A3_00);

        // Early marker on slot 2.
        frame4(32'hB0B1B2B3, 0);
        cyc(1'b1, 1'b1, 8'hC0);
        cyc(1'b1, 1'b0, 8'hC1);
        cyc(1'b1, 1'b1, 8'hD0);
        cyc(1'b1, 1'b0, 8'hD1);
        cyc(1'b1, 1'b0, 8'hD2);
        cyc(1'b1, 1'b0, 8'hD3);
        cyc(1'b0, 1'b0, 8'h00);
        chk("early_marker", 64'({O0, O1, O2, O3, err_cnt}), 64'hD0D1D2D3_01);

        // Missing marker, then relock.
        cyc(1'b1, 1'b0, 8'hEE);
        cyc(1'b0, 1'b0, 8'h00);
        chk("missing_marker_unlock", 64'({locked, sel}), 64'd0);
        frame4(32'hE0E1E2E3, 0);

        // Gapped frame.
        frame4(32'h01020304, 5);
        cyc(1'b0, 1'b0, 8'h00);

        // Reset mid-frame.
        cyc(1'b1, 1'b1, 8'h91);
        cyc(1'b1, 1'b0, 8'h92);
        do_reset();
        cyc(1'b0, 1'b0, 8'h00);
        chk("midframe_rst", 64'({O0, O1, O2, O3, frame_cnt, err_cnt}), 64'd0);

        // Randomized stream with occasional marker faults and idle gaps.
        begin
            int k = 0;
            for (int i = 0; i < 1500; i++) begin
                bit v = ($urandom_range(0, 3) != 0);
                bit f = ((k % 4) == 0) ^ ($urandom_range(0, 19) == 0);
                cyc(v, v & f, 8'($urandom));
                if (v) k++;
            end
        end

        // Saturate the error counter: repeated markers while at slot 1.
        cyc(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < (1 << ERR_W) + 3; i++) cyc(1'b1, 1'b1, 8'($urandom));
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        chk("err_saturate", 64'(err_cnt), 64'({ERR_W{1'b1}}));
        chk("frames_drained", 64'(exp_frames.size()), 64'd0);
        chk("errs_drained", 64'(exp_errs.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
